data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/data_mem_responder.sv | 148 ++++++++++++++
 tb/tb_data_mem_responder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/beat bus between a burst requester and data_mem_responder.
// The master drives the request and write data; the slave answers with beats and status.
interface data_mem_responder_if #(
  parameter int A = 32,
  parameter int L = 8
);
  logic         req_i;
  logic         we_i;
  logic [A-1:0] addr_i;
  logic [4:0]   len_i;
  logic [L-1:0] wdata_i;
  logic [L-1:0] rdata_o;
  logic         rvalid_o;
  logic         wready_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;

  modport master (
    output req_i, we_i, addr_i, len_i, wdata_i,
    input  rdata_o, rvalid_o, wready_o, busy_o, done_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, len_i, wdata_i,
    output rdata_o, rvalid_o, wready_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Burst responder in front of a DEPTH x L storage array.
// Accepts one read/write burst at a time, waits LAT cycles, then moves one beat per cycle.
//
// state  | meaning
// S_IDLE | waiting for req_i; the only state that samples a request
// S_WAIT | latency countdown, no beats
// S_XFER | one read or write beat per cycle
// S_DONE | one-cycle completion pulse
// S_ERR  | one-cycle completion pulse with range error, storage untouched
module data_mem_responder #(
  parameter int A     = 32,
  parameter int L     = 8,
  parameter int V     = 20,
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input logic                 CLK,
  input logic                 RST,
  data_mem_responder_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_XFER, S_DONE, S_ERR} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_ptr;
  logic [4:0]    r_left;
  logic [3:0]    r_wait;
  logic          r_we;
  logic [L-1:0]  r_mem [DEPTH];

  logic [4:0]    w_len;
  logic [A:0]    w_end;
  logic          w_range_err;
  logic          w_accept;
  logic          w_last;
  logic          w_wait_tc;
  logic          w_rvalid;
  logic          w_wready;
  logic          w_busy;
  logic          w_done;
  logic          w_err;

  // Clamp the requested length into 1..V.
  always_comb begin
    w_len = bus.len_i;
    if (bus.len_i == 5'd0)
      w_len = 5'd1;
    else if (bus.len_i > 5'(V))
      w_len = 5'(V);
  end

  // One extra bit keeps the end-address sum from wrapping.
  assign w_end       = {1'b0, bus.addr_i} + (A+1)'(w_len);
  assign w_range_err = w_end > (A+1)'(DEPTH);
  assign w_accept    = (r_state == S_IDLE) && bus.req_i;
  assign w_last      = (r_left == 5'd1);
  assign w_wait_tc   = (r_wait == 4'd0);

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state and decoded outputs.
  always_comb begin
    w_next   = r_state;
    w_rvalid = 1'b0;
    w_wready = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_i) begin
          if (w_range_err)
            w_next = S_ERR;
          else if (LAT == 0)
            w_next = S_XFER;
          else
            w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (w_wait_tc)
          w_next = S_XFER;
      end
      S_XFER: begin
        w_busy   = 1'b1;
        w_rvalid = !r_we;
        w_wready = r_we;
        if (w_last)
          w_next = S_DONE;
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_err  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Burst bookkeeping: address pointer, remaining-beat and latency down-counters.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ptr  <= '0;
      r_left <= '0;
      r_wait <= '0;
      r_we   <= 1'b0;
    end else if (w_accept) begin
      r_we   <= bus.we_i;
      r_ptr  <= bus.addr_i[AW-1:0];
      r_left <= w_len;
      r_wait <= 4'(LAT - 1);
    end else if (r_state == S_WAIT) begin
      if (!w_wait_tc)
        r_wait <= r_wait - 4'd1;
    end else if (r_state == S_XFER) begin
      r_ptr  <= r_ptr + AW'(1);
      r_left <= r_left - 5'd1;
    end
  end

  // Storage has no reset so contents survive RST.
  always_ff @(posedge CLK) begin
    if (w_wready)
      r_mem[r_ptr] <= bus.wdata_i;
  end

  assign bus.rdata_o  = w_rvalid ? r_mem[r_ptr] : '0;
  assign bus.rvalid_o = w_rvalid;
  assign bus.wready_o = w_wready;
  assign bus.busy_o   = w_busy;
  assign bus.done_o   = w_done;
  assign bus.err_o    = w_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: timing and data of each burst are
// predicted from the burst rules with a flat memory array model.
module tb_data_mem_responder;
  localparam int A     = 32;
  localparam int L     = 8;
  localparam int V     = 20;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  data_mem_responder_if #(.A(A), .L(L)) bus();

  data_mem_responder #(.A(A), .L(L), .V(V), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [L-1:0] mem_model [DEPTH];
  logic [L-1:0] wbuf [V];

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy_o !== 1'b0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_timeout: busy_o=%b, required 0", bus.busy_o);
    end
  endtask

  // Issue one burst and check every cycle until it has finished.
  task automatic run_burst(input bit we, input logic [31:0] addr, input logic [4:0] len, input bit hold);
    int eff;
    bit err;
    eff = (len == 5'd0) ? 1 : ((int'(len) > V) ? V : int'(len));
    err = (longint'(addr) + longint'(eff)) > longint'(DEPTH);
    wait_idle();
    bus.req_i  = 1'b1;
    bus.we_i   = we;
    bus.addr_i = addr;
    bus.len_i  = len;
    @(negedge CLK);
    if (!hold) bus.req_i = 1'b0;
    if (err) begin
      n_cmp++;
      if ({bus.done_o, bus.err_o, bus.rvalid_o, bus.wready_o, bus.busy_o} !== 5'b11001) begin
        n_bad++;
        $display("FAIL err_pulse addr=%0h len=%0d: done,err,rvalid,wready,busy=%b, required 11001",
                 addr, len, {bus.done_o, bus.err_o, bus.rvalid_o, bus.wready_o, bus.busy_o});
      end
      @(negedge CLK);
      n_cmp++;
      if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
        n_bad++;
        $display("FAIL err_return: busy,done=%b%b, required 00", bus.busy_o, bus.done_o);
      end
    end else begin
      for (int c = 0; c < LAT; c++) begin
        n_cmp++;
        if ({bus.busy_o, bus.rvalid_o, bus.wready_o, bus.done_o} !== 4'b1000 || bus.rdata_o !== '0) begin
          n_bad++;
          $display("FAIL wait_phase cyc=%0d: busy,rvalid,wready,done=%b rdata=%0h, required 1000 rdata 0",
                   c, {bus.busy_o, bus.rvalid_o, bus.wready_o, bus.done_o}, bus.rdata_o);
        end
        @(negedge CLK);
      end
      for (int k = 0; k < eff; k++) begin
        if (we) begin
          n_cmp++;
          if (bus.wready_o !== 1'b1 || bus.rvalid_o !== 1'b0 || bus.rdata_o !== '0) begin
            n_bad++;
            $display("FAIL write_beat k=%0d: wready=%b rvalid=%b rdata=%0h, required 1 0 0",
                     k, bus.wready_o, bus.rvalid_o, bus.rdata_o);
          end
          bus.wdata_i = wbuf[k];
          mem_model[int'(addr) + k] = wbuf[k];
        end else begin
          n_cmp++;
          if (bus.rvalid_o !== 1'b1 || bus.wready_o !== 1'b0 || bus.rdata_o !== mem_model[int'(addr) + k]) begin
            n_bad++;
            $display("FAIL read_beat addr=%0d k=%0d: rvalid=%b wready=%b rdata=%0h, required 1 0 %0h",
                     addr, k, bus.rvalid_o, bus.wready_o, bus.rdata_o, mem_model[int'(addr) + k]);
          end
        end
        @(negedge CLK);
      end
      n_cmp++;
      if ({bus.busy_o, bus.done_o, bus.err_o, bus.rvalid_o, bus.wready_o} !== 5'b11000) begin
        n_bad++;
        $display("FAIL done_pulse: busy,done,err,rvalid,wready=%b, required 11000",
                 {bus.busy_o, bus.done_o, bus.err_o, bus.rvalid_o, bus.wready_o});
      end
      @(negedge CLK);
      if (!hold) begin
        n_cmp++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
          n_bad++;
          $display("FAIL done_return: busy,done=%b%b, required 00", bus.busy_o, bus.done_o);
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = '0;
    bus.len_i   = '0;
    bus.wdata_i = '0;
    #2 RST = 1'b0;
    #1;
    n_cmp++;
    if ({bus.rvalid_o, bus.wready_o, bus.busy_o, bus.done_o, bus.err_o} !== 5'b0 || bus.rdata_o !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: flags=%b rdata=%0h, required 0 0",
               {bus.rvalid_o, bus.wready_o, bus.busy_o, bus.done_o, bus.err_o}, bus.rdata_o);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  // Fill the whole array so every later read has a known expected value.
  task automatic test_fill();
    for (int base = 0; base < DEPTH; base += V) begin
      for (int k = 0; k < V; k++) wbuf[k] = L'($urandom);
      run_burst(1'b1, 32'(base), 5'((DEPTH - base < V) ? DEPTH - base : V), 1'b0);
    end
  endtask

  task automatic test_single();
    wbuf[0] = 8'hA5;
    run_burst(1'b1, 32'd5, 5'd1, 1'b0);
    run_burst(1'b0, 32'd5, 5'd1, 1'b0);
  endtask

  task automatic test_long_burst();
    for (int k = 0; k < V; k++) wbuf[k] = L'(k);
    run_burst(1'b1, 32'd100, 5'd20, 1'b0);
    run_burst(1'b0, 32'd100, 5'd20, 1'b0);
  endtask

  task automatic test_range_err();
    for (int k = 0; k < V; k++) wbuf[k] = L'($urandom);
    run_burst(1'b0, 32'd1020, 5'd8, 1'b0);
    run_burst(1'b1, 32'd1020, 5'd8, 1'b0);
    run_burst(1'b0, 32'hFFFF_FFF0, 5'd20, 1'b0);
    run_burst(1'b0, 32'd1004, 5'd20, 1'b0);
    run_burst(1'b0, 32'd1016, 5'd8, 1'b0);
  endtask

  task automatic test_len_clamp();
    for (int k = 0; k < V; k++) wbuf[k] = L'($urandom);
    run_burst(1'b1, 32'd200, 5'd0, 1'b0);
    for (int k = 0; k < V; k++) wbuf[k] = L'($urandom);
    run_burst(1'b1, 32'd200, 5'd31, 1'b0);
    run_burst(1'b0, 32'd199, 5'd31, 1'b0);
  endtask

  task automatic test_hold_req();
    int n;
    run_burst(1'b0, 32'd300, 5'd4, 1'b1);
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_idle_gap: busy=%b, required 0", bus.busy_o);
    end
    @(negedge CLK);
    n_cmp++;
    if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_reaccept: busy,done=%b%b, required 10", bus.busy_o, bus.done_o);
    end
    bus.req_i = 1'b0;
    n = 0;
    while (bus.done_o !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    n_cmp++;
    if (n != LAT + 4) begin
      n_bad++;
      $display("FAIL hold_second_done: cycles=%0d, required %0d", n, LAT + 4);
    end
    @(negedge CLK);
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n;
    for (int k = 0; k < V; k++) wbuf[k] = L'($urandom);
    wait_idle();
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b1;
    bus.addr_i = 32'd0;
    bus.len_i  = 5'd6;
    @(negedge CLK);
    bus.req_i = 1'b0;
    repeat (LAT) @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (bus.wready_o !== 1'b1) begin
        n_bad++;
        $display("FAIL midrst_beat k=%0d: wready=%b, required 1", k, bus.wready_o);
      end
      bus.wdata_i = wbuf[k];
      mem_model[k] = wbuf[k];
      @(negedge CLK);
    end
    bus.wdata_i = wbuf[3];
    RST = 1'b0;
    #1;
    n_cmp++;
    if ({bus.rvalid_o, bus.wready_o, bus.busy_o, bus.done_o, bus.err_o} !== 5'b0 || bus.rdata_o !== '0) begin
      n_bad++;
      $display("FAIL midrst_outputs: flags=%b rdata=%0h, required 0 0",
               {bus.rvalid_o, bus.wready_o, bus.busy_o, bus.done_o, bus.err_o}, bus.rdata_o);
    end
    @(negedge CLK);
    RST = 1'b1;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) n++;
    end
    n_cmp++;
    if (n != 0) begin
      n_bad++;
      $display("FAIL midrst_no_done: active cycles=%0d, required 0", n);
    end
    run_burst(1'b0, 32'd0, 5'd6, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < V; k++) wbuf[k] = L'($urandom);
      run_burst(1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH + 16)),
                5'($urandom_range(0, 31)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_single();
    test_long_burst();
    test_range_err();
    test_len_clamp();
    test_hold_req();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
